// File: rtl/aes_ctrl_pkg.sv
// Shared constants and types for the AES round-scheduling controller.
package aes_ctrl_pkg;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned RND_W     = 4;

    typedef struct packed {
        logic             occ;
        logic [RND_W-1:0] rnd;
    } slot_t;

    // Indexed directly by the 4-bit round number; 0 and 11..15 yield 00.
    localparam logic [7:0] RCON_TAB [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1B, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/aes_round_sched_if.sv
// Handshake and datapath-control signals between the round scheduler and the AES datapath.
interface aes_round_sched_if;

    logic       in_valid;
    logic       in_ready;
    logic       ld_sel;
    logic       empty_in;
    logic [7:0] Rcon_in;
    logic       last_rnd;
    logic       empty;
    logic       out_valid;
    logic       busy;
    logic       err;

    modport master (
        input  in_valid, empty,
        output in_ready, ld_sel, empty_in, Rcon_in, last_rnd, out_valid, busy, err
    );

    modport slave (
        output in_valid, empty,
        input  in_ready, ld_sel, empty_in, Rcon_in, last_rnd, out_valid, busy, err
    );

endinterface

// File: rtl/aes_rcon_rom.sv
// Combinational AES round-constant lookup.
module aes_rcon_rom
    import aes_ctrl_pkg::*;
(
    input  logic [RND_W-1:0] i_rnd,
    output logic [7:0]       o_rcon
);

    assign o_rcon = RCON_TAB[i_rnd];

endmodule

// File: rtl/aes_round_sched.sv
// Round scheduler for a LAT-deep iterative AES pipeline: a ring of slot records tracks
// which pipeline slot holds which round, deciding recirculate / complete / inject / bubble.
module aes_round_sched
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned LAT = 2,
    parameter int unsigned NR  = NR_AES128
) (
    input logic              clock,
    input logic              reset_n,
    aes_round_sched_if.master bus
);

    localparam logic [RND_W-1:0] LastRnd = RND_W'(NR);

    slot_t          r_ring [LAT];
    logic [LAT-1:0] r_warm;
    logic           r_err;

    slot_t      w_tail;
    slot_t      w_next;
    logic       w_done;
    logic       w_recirc;
    logic       w_in_ready;
    logic       w_ld_sel;
    logic       w_empty_in;
    logic       w_out_valid;
    logic       w_busy;
    logic [7:0] w_rcon;

    assign w_tail   = r_ring[LAT-1];
    assign w_done   = w_tail.occ && (w_tail.rnd == LastRnd);
    assign w_recirc = w_tail.occ && !w_done;

    // A completing slot is free for injection in the same cycle.
    always_comb begin
        w_in_ready  = 1'b0;
        w_ld_sel    = 1'b0;
        w_empty_in  = 1'b1;
        w_out_valid = 1'b0;
        w_next      = '0;
        if (reset_n) begin
            w_out_valid = w_done;
            if (w_recirc) begin
                w_empty_in = 1'b0;
                w_next.occ = 1'b1;
                w_next.rnd = w_tail.rnd + RND_W'(1);
            end else begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_ld_sel   = 1'b1;
                    w_empty_in = 1'b0;
                    w_next.occ = 1'b1;
                    w_next.rnd = RND_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            w_busy = w_busy | r_ring[i].occ;
        end
    end

    aes_rcon_rom u_rcon_rom (
        .i_rnd  (w_next.rnd),
        .o_rcon (w_rcon)
    );

    // r_warm fills with ones after release so the datapath's stale empty flags are ignored.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) begin
                r_ring[i] <= '0;
            end
            r_warm <= '0;
            r_err  <= 1'b0;
        end else begin
            r_ring[0] <= w_next;
            for (int i = 1; i < LAT; i++) begin
                r_ring[i] <= r_ring[i-1];
            end
            r_warm[0] <= 1'b1;
            for (int i = 1; i < LAT; i++) begin
                r_warm[i] <= r_warm[i-1];
            end
            if (r_warm[LAT-1] && (bus.empty != !w_tail.occ)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.ld_sel    = w_ld_sel;
    assign bus.empty_in  = w_empty_in;
    assign bus.Rcon_in   = w_rcon;
    assign bus.last_rnd  = w_next.occ && (w_next.rnd == LastRnd);
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = reset_n && w_busy;
    assign bus.err       = r_err;

endmodule
